// File: rtl/hilo_muldiv_ctrl_if.sv
// hilo_muldiv_ctrl_if
//   Bundle between the EX stage and the HI/LO multiply/divide sequencer.
//   master (EX stage / hazard unit side):
//     drives   ex_valid, ex_op[2:0], ex_a, ex_b, cancel
//     observes stall, busy, hi, lo, div_zero
//   slave (hilo_muldiv_ctrl side): the reverse directions.
interface hilo_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             ex_valid;
  logic [2:0]       ex_op;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic             cancel;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output ex_valid, ex_op, ex_a, ex_b, cancel,
    input  stall, busy, hi, lo, div_zero
  );

  modport slave (
    input  ex_valid, ex_op, ex_a, ex_b, cancel,
    output stall, busy, hi, lo, div_zero
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   Owns the MIPS HI/LO register pair and sequences MULT/MULTU (one
//   registered multiply cycle) and DIV/DIVU (32-step restoring divider).
//   MTHI/MTLO write HI/LO directly from IDLE with no stall.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (state IDLE, HI=LO=0)
//   bus  - slave side of hilo_muldiv_ctrl_if:
//          ex_valid/ex_op/ex_a/ex_b/cancel in; stall/busy/hi/lo/div_zero out
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  hilo_muldiv_ctrl_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sgn);
    logic signed [2*WIDTH-1:0] sa;
    logic signed [2*WIDTH-1:0] sb;
    sa = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    sb = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    return sa * sb;
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             sgn_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             dz_q;

  logic             is_long;
  logic             div_sgn;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  assign is_long = (bus.ex_op == OP_MULT) || (bus.ex_op == OP_MULTU) ||
                   (bus.ex_op == OP_DIV)  || (bus.ex_op == OP_DIVU);
  assign div_sgn = (bus.ex_op == OP_DIV);

  // One restoring step. The remainder is always below the divisor, so the
  // shifted value fits in WIDTH+1 bits and the MSB of the difference is a
  // reliable borrow.
  assign trial_d = {rem_q, quo_q[WIDTH-1]} - {1'b0, b_q};
  assign rem_d   = trial_d[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]}
                                  : trial_d[WIDTH-1:0];
  assign quo_d   = {quo_q[WIDTH-2:0], ~trial_d[WIDTH]};

  // Stall the accept cycle combinationally so EX holds the instruction
  // until DONE; cancel/reset drop it immediately.
  assign bus.stall    = !rst && !bus.cancel &&
                        ((state_q == S_MUL) || (state_q == S_DIV) ||
                         ((state_q == S_IDLE) && bus.ex_valid && is_long));
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.div_zero = (state_q == S_DONE) && dz_q && !bus.cancel;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

  // Result staging reuses rem_q/quo_q: the multiply parks {hi,lo} there and
  // divide-by-zero parks {dividend, all-ones}, so DONE commits uniformly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.cancel) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.ex_valid) begin
            case (bus.ex_op)
              OP_MTHI: hi_q <= bus.ex_a;
              OP_MTLO: lo_q <= bus.ex_a;
              OP_MULT, OP_MULTU: begin
                a_q     <= bus.ex_a;
                b_q     <= bus.ex_b;
                sgn_q   <= (bus.ex_op == OP_MULT);
                dz_q    <= 1'b0;
                state_q <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                cnt_q <= '0;
                if (bus.ex_b == '0) begin
                  dz_q    <= 1'b1;
                  quo_q   <= '1;
                  rem_q   <= bus.ex_a;
                  qneg_q  <= 1'b0;
                  rneg_q  <= 1'b0;
                  state_q <= S_DONE;
                end else begin
                  dz_q    <= 1'b0;
                  rem_q   <= '0;
                  quo_q   <= div_sgn ? abs_val(bus.ex_a) : bus.ex_a;
                  b_q     <= div_sgn ? abs_val(bus.ex_b) : bus.ex_b;
                  qneg_q  <= div_sgn && (bus.ex_a[WIDTH-1] ^ bus.ex_b[WIDTH-1]);
                  rneg_q  <= div_sgn && bus.ex_a[WIDTH-1];
                  state_q <= S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          {rem_q, quo_q} <= mul_full(a_q, b_q, sgn_q);
          qneg_q         <= 1'b0;
          rneg_q         <= 1'b0;
          state_q        <= S_DONE;
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= S_DONE;
        end
        S_DONE: begin
          lo_q    <= cond_neg(quo_q, qneg_q);
          hi_q    <= cond_neg(rem_q, rneg_q);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl
//   Directed and randomized checks of hilo_muldiv_ctrl against a plain
//   arithmetic reference of the MIPS HI/LO instructions.
module tb_hilo_muldiv_ctrl;

  localparam logic [2:0] NOP   = 3'd0;
  localparam logic [2:0] MULT  = 3'd1;
  localparam logic [2:0] MULTU = 3'd2;
  localparam logic [2:0] DIV   = 3'd3;
  localparam logic [2:0] DIVU  = 3'd4;
  localparam logic [2:0] MTHI  = 3'd5;
  localparam logic [2:0] MTLO  = 3'd6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_muldiv_ctrl_if #(.WIDTH(32)) bus ();

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: architectural effect of one instruction plus its stall
  // length and number of divide-by-zero pulses.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nst, output int ndz);
    int     ia, ib;
    longint sa, sb, p, q, r;
    logic [63:0] up;
    ia = a; ib = b;
    sa = ia; sb = ib;
    nst = 0; ndz = 0;
    case (op)
      MULT: begin
        p = sa * sb;
        exp_hi = p[63:32]; exp_lo = p[31:0]; nst = 2;
      end
      MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        exp_hi = up[63:32]; exp_lo = up[31:0]; nst = 2;
      end
      DIV, DIVU: begin
        if (b == 0) begin
          exp_lo = 32'hFFFF_FFFF; exp_hi = a; nst = 1; ndz = 1;
        end else if (op == DIV) begin
          q = sa / sb; r = sa % sb;
          exp_lo = q[31:0]; exp_hi = r[31:0]; nst = 33;
        end else begin
          exp_lo = a / b; exp_hi = a % b; nst = 33;
        end
      end
      MTHI: exp_hi = a;
      MTLO: exp_lo = a;
      default: ;
    endcase
  endtask

  // Called at posedge+1 with the block idle. Presents the instruction,
  // confirms the previous result on HI/LO, then holds it until stall drops.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int nst, ndz, cyc, exp_nst, exp_ndz;
    bit left;
    bus.ex_valid = 1'b1; bus.ex_op = op; bus.ex_a = a; bus.ex_b = b;
    nst = 0; ndz = 0; cyc = 0; left = 0;
    @(negedge clk);
    check({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
    check({tag, "_hi_prev"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo_prev"}, 64'(bus.lo), 64'(exp_lo));
    while (!left && cyc < 64) begin
      if (cyc > 0) @(negedge clk);
      if (bus.stall) nst++;
      if (bus.div_zero) ndz++;
      if (!bus.stall) left = 1;
      @(posedge clk); #1;
      cyc++;
    end
    bus.ex_valid = 1'b0; bus.ex_op = NOP;
    if (!left) check({tag, "_timeout"}, 64'd1, 64'd0);
    model(op, a, b, exp_nst, exp_ndz);
    check({tag, "_stall_cycles"}, 64'(nst), 64'(exp_nst));
    check({tag, "_dz_pulses"}, 64'(ndz), 64'(exp_ndz));
  endtask

  // Presents an instruction and raises cancel k cycles after acceptance;
  // HI/LO must be left untouched (confirmed by the next run_op).
  task automatic cancel_at(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int k, input string tag);
    bus.ex_valid = 1'b1; bus.ex_op = op; bus.ex_a = a; bus.ex_b = b;
    bus.cancel = (k == 0);
    repeat (k) begin @(posedge clk); #1; end
    bus.cancel = 1'b1;
    @(negedge clk);
    check({tag, "_cancel_stall"}, 64'(bus.stall), 64'd0);
    check({tag, "_cancel_dz"}, 64'(bus.div_zero), 64'd0);
    check({tag, "_cancel_busy"}, 64'(bus.busy), 64'(k > 0));
    @(posedge clk); #1;
    bus.cancel = 1'b0; bus.ex_valid = 1'b0; bus.ex_op = NOP;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_op = NOP; bus.ex_a = '0; bus.ex_b = '0; bus.cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_dz", 64'(bus.div_zero), 64'd0);
    @(posedge clk); #1;

    run_op(MTHI,  32'hDEAD_BEEF, 32'h0, "mthi");
    run_op(MTLO,  32'h1234_5678, 32'h0, "mtlo");
    run_op(MULT,  32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
    run_op(MULTU, 32'hFFFF_FFFD, 32'd5, "multu");
    run_op(DIVU,  32'd100,       32'd7, "divu_100_7");
    run_op(DIV,   32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_op(DIV,   32'h0000_0055, 32'd0, "div_zero");
    cancel_at(DIVU, 32'd1000, 32'd3, 10, "divu_cancel10");
    run_op(MULT,  32'd1234, 32'hFFFF_FF00, "mult_after_cancel");
    cancel_at(MTHI, 32'hCAFE_F00D, 32'h0, 0, "mthi_cancel");
    cancel_at(MULT, 32'd77, 32'd99, 2, "mult_cancel_done");
    cancel_at(DIV, 32'd9, 32'd0, 1, "divz_cancel_done");
    run_op(NOP,   32'hFFFF_FFFF, 32'd1, "nop");
    run_op(3'd7,  32'hFFFF_FFFF, 32'd1, "op7");

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick(); b = pick();
      if ($urandom_range(0, 5) == 0) b = '0;
      if ((op == DIV || op == DIVU) && b != 0 && $urandom_range(0, 5) == 0)
        cancel_at(op, a, b, $urandom_range(0, 33), "rnd_cancel");
      else
        run_op(op, a, b, "rnd");
    end

    run_op(MTHI, 32'hA5A5_0001, 32'h0, "pre_rst_hi");
    run_op(MTLO, 32'h5A5A_0002, 32'h0, "pre_rst_lo");
    run_op(NOP,  32'h0, 32'h0, "pre_rst_chk");
    bus.ex_valid = 1'b1; bus.ex_op = DIVU; bus.ex_a = 32'd1000; bus.ex_b = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; bus.ex_valid = 1'b0; bus.ex_op = NOP;
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    check("post_rst_hi", 64'(bus.hi), 64'd0);
    check("post_rst_lo", 64'(bus.lo), 64'd0);
    check("post_rst_stall", 64'(bus.stall), 64'd0);
    check("post_rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    run_op(MULTU, 32'h0001_0000, 32'h0001_0000, "multu_after_rst");
    run_op(NOP, 32'h0, 32'h0, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Sequencer and owner of the HI/LO register pair for the MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs an iterative 32-step restoring divider or a registered multiply. It raises `stall` to the hazard unit until the result is committed to HI/LO. MFHI/MFLO read the `hi`/`lo` outputs directly.

## Interface
- `WIDTH`, 32: operand, HI and LO width. Only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: EX stage holds a HI/LO-class instruction.
- `ex_op` in 3: operation code.
  - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
  - 7 is treated as NOP.
- `ex_a` in 32: rs value (dividend / multiplicand / MTxx source).
- `ex_b` in 32: rt value (divisor / multiplier).
- `cancel` in 1: exception/flush; aborts any in-flight operation.
- `stall` out 1: hold the pipeline; EX must not advance while high.
- `busy` out 1: state is not IDLE.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `div_zero` out 1: one-cycle pulse in DONE when the divisor was 0.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset values: state IDLE, `hi`=0, `lo`=0, `stall`=0, `busy`=0, `div_zero`=0, iteration counter 0.
- IDLE, with `ex_valid`=1 and `cancel`=0:
  - MTHI: `hi`<=`ex_a` at the end of the cycle; no stall; stay in IDLE.
  - MTLO: same as MTHI, writing `lo`.
  - MULT/MULTU: latch operands and the signed flag; go to MUL; `stall`=1 combinationally in the accept cycle.
  - DIV/DIVU with `ex_b`≠0: latch |a|, |b| (absolute values for DIV, raw for DIVU), quotient sign = a[31]^b[31] and remainder sign = a[31] (DIV only); clear counter; go to DIV; `stall`=1.
  - DIV/DIVU with `ex_b`=0: latch the zero flag; go directly to DONE; `stall`=1.
  - NOP or reserved code: no action.
- MUL, one cycle:
  - Compute the 64-bit product, signed or unsigned per the flag, into a result register.
  - Go to DONE. `stall`=1.
- DIV, 32 cycles:
  - Each cycle performs one restoring step: shift {rem,quo} left by 1, trial-subtract the divisor from rem, keep the result if non-negative, set the quotient LSB accordingly.
  - The counter increments 0→31; at 31 go to DONE. `stall`=1 throughout.
- DONE, one cycle:
  - Commit `lo` and `hi` at the end of the cycle.
  - Multiply: `lo`=product[31:0], `hi`=product[63:32].
  - Divide: `lo`=quotient, `hi`=remainder, each two's-complement negated if its sign flag is set.
  - Divide by zero: `lo`=0xFFFFFFFF, `hi`=`ex_a` as latched; `div_zero`=1.
  - `stall`=0, so the instruction leaves EX at the end of this cycle.
  - `ex_valid` is ignored in DONE, so the still-present instruction is not re-accepted.
  - Next state IDLE.
- Arithmetic rules:
  - All results are taken modulo 2^32.
  - DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- Cancel:
  - In any state, `cancel`=1 forces state IDLE at the next edge.
  - No HI/LO write occurs that cycle, including a DONE cycle, an IDLE MTHI/MTLO, or an accept.
  - `stall`=0 and `div_zero`=0 while `cancel`=1.
- Reset mid-operation: same as cancel, and HI/LO return to 0.
- `busy` = (state≠IDLE).

## Timing
- T is the accept cycle.
- MTHI/MTLO: 0 stall cycles; the value is visible on `hi`/`lo` in T+1.
- MULT/MULTU: `stall` high in T and T+1 (MUL). DONE is T+2 with `stall` low. The result is visible in T+3. Total 2 stall cycles.
- DIV/DIVU: `stall` high in T..T+32 (accept cycle plus 32 DIV cycles). DONE is T+33. The result is visible in T+34. Total 33 stall cycles.
- Divide by zero: `stall` high in T only. DONE is T+1 with the `div_zero` pulse. The result is visible in T+2.
- Back-to-back: a new operation can be accepted in the cycle after DONE, with no bubble beyond the returned IDLE cycle.
- `stall` is combinational from state and the IDLE decode of `ex_valid`/`ex_op`. `hi`, `lo`, `busy` and `div_zero` are registered or state-derived.

## Test plan
- Reset: assert `rst` 2 cycles mid-DIV → `hi`=`lo`=0, `stall`=0, `busy`=0 next cycle.
- MTHI 0xDEADBEEF then MTLO 0x12345678 in consecutive cycles:
  - `stall` never high.
  - `hi`=0xDEADBEEF, `lo`=0x12345678.
- MULT with a=0xFFFFFFFD (−3), b=5:
  - `stall` high for exactly 2 cycles.
  - `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- MULTU with the same operands → `hi`=0x00000004, `lo`=0xFFFFFFF1.
- DIVU a=100, b=7:
  - `stall` high for exactly 33 cycles.
  - `lo`=14, `hi`=2.
- DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIV a=0x55, b=0:
  - `stall` for 1 cycle, `div_zero` pulses once.
  - `lo`=0xFFFFFFFF, `hi`=0x55.
- Cancel during DIVU at T+10:
  - HI/LO unchanged, `stall` drops the same cycle, IDLE next cycle.
  - A MULT accepted in the following cycle completes with a correct result.
